// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    localparam int unsigned SRC_ALU    = 0;
    localparam int unsigned SRC_MEM    = 1;
    localparam int unsigned SRC_MULDIV = 2;

    localparam logic [REG_ADDR_W-1:0] NO_WRITE_ADDR = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_pick #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt_c,
    output logic [PTR_W-1:0]   idx_c
);

    logic             found;
    logic [PTR_W:0]   pos;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            // Offset i from ptr, wrapped into 0..NUM_SRC-1
            pos = {1'b0, ptr} + (PTR_W+1)'(i);
            if (pos >= (PTR_W+1)'(NUM_SRC)) begin
                pos = pos - (PTR_W+1)'(NUM_SRC);
            end
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (!found && pos == (PTR_W+1)'(k) && req[k]) begin
                    found    = 1'b1;
                    gnt_c[k] = 1'b1;
                    idx_c    = PTR_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source one-entry buffers drained round-robin into the
// register file's single write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [REG_ADDR_W*NUM_SRC-1:0] src_waddr,
    input  logic [DATA_W*NUM_SRC-1:0]    src_wdata,
    input  logic                         flush,
    output logic [REG_ADDR_W-1:0]        wb_waddr,
    output logic [DATA_W-1:0]            wb_wdata,
    output logic                         wb_busy
);

    logic [NUM_SRC-1:0]    buf_v_q, buf_v_d;
    wb_entry_t             buf_q [NUM_SRC];
    wb_entry_t             buf_d [NUM_SRC];
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [REG_ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
    logic [DATA_W-1:0]     wb_wdata_q, wb_wdata_d;

    logic [NUM_SRC-1:0]    grant_c;
    logic [PTR_W-1:0]      gnt_idx_c;
    wb_entry_t             sel_c;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (buf_v_q),
        .ptr   (rr_ptr_q),
        .gnt_c (grant_c),
        .idx_c (gnt_idx_c)
    );

    // A granted buffer drains this edge, so it may refill at the same edge
    assign src_ready = {NUM_SRC{resetn && !flush}} & (~buf_v_q | grant_c);
    assign wb_busy   = |buf_v_q;
    assign wb_waddr  = wb_waddr_q;
    assign wb_wdata  = wb_wdata_q;

    always_comb begin
        buf_v_d    = buf_v_q & ~grant_c;
        buf_d      = buf_q;
        sel_c      = '0;
        wb_waddr_d = NO_WRITE_ADDR;
        wb_wdata_d = wb_wdata_q;
        rr_ptr_d   = rr_ptr_q;

        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            // Results targeting x0 are accepted but never buffered
            if (src_valid[i] && src_ready[i] &&
                src_waddr[REG_ADDR_W*i +: REG_ADDR_W] != NO_WRITE_ADDR) begin
                buf_v_d[i]    = 1'b1;
                buf_d[i].addr = src_waddr[REG_ADDR_W*i +: REG_ADDR_W];
                buf_d[i].data = src_wdata[DATA_W*i +: DATA_W];
            end
            if (grant_c[i]) begin
                sel_c = buf_q[i];
            end
        end

        if (flush) begin
            buf_v_d = '0;
        end else if (|grant_c) begin
            wb_waddr_d = sel_c.addr;
            wb_wdata_d = sel_c.data;
            rr_ptr_d   = (gnt_idx_c == PTR_W'(NUM_SRC-1)) ? '0 : gnt_idx_c + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_v_q    <= '0;
            rr_ptr_q   <= '0;
            wb_waddr_q <= NO_WRITE_ADDR;
            wb_wdata_q <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            buf_v_q    <= buf_v_d;
            rr_ptr_q   <= rr_ptr_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ordering, fairness, x0 drop, flush and async reset.
module tb_wb_arbiter;

    logic        clk;
    logic        resetn;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_waddr;
    logic [95:0] src_wdata;
    logic        flush;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_busy;

    int checks;
    int errors;
    int cnt [3];

    wb_arbiter #(
        .NUM_SRC (3),
        .PTR_W   (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_waddr (src_waddr),
        .src_wdata (src_wdata),
        .flush     (flush),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .wb_busy   (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
        src_waddr[5*i +: 5]   = a;
        src_wdata[32*i +: 32] = d;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cnt[0]    = 0;
        cnt[1]    = 0;
        cnt[2]    = 0;
        resetn    = 1'b0;
        flush     = 1'b0;
        src_valid = 3'b111;
        src_waddr = '0;
        src_wdata = '0;

        // Reset state
        #12;
        chk("rst_waddr", 64'(wb_waddr), 64'd0);
        chk("rst_wdata", 64'(wb_wdata), 64'd0);
        chk("rst_busy",  64'(wb_busy),  64'd0);
        chk("rst_ready", 64'(src_ready), 64'd0);
        src_valid = 3'b000;
        @(negedge clk);
        resetn = 1'b1;

        // Simultaneous arrival on all sources
        set_src(0, 5'd1, 32'hA000_0000);
        set_src(1, 5'd2, 32'hA111_1111);
        set_src(2, 5'd3, 32'hA222_2222);
        src_valid = 3'b111;
        #1;
        chk("sim_ready0", 64'(src_ready), 64'b111);
        step();
        src_valid = 3'b000;
        chk("sim_lat_waddr", 64'(wb_waddr), 64'd0);
        chk("sim_lat_busy",  64'(wb_busy),  64'd1);
        step();
        chk("sim_w1_addr", 64'(wb_waddr), 64'd1);
        chk("sim_w1_data", 64'(wb_wdata), 64'hA000_0000);
        chk("sim_ready1",  64'(src_ready), 64'b011);
        step();
        chk("sim_w2_addr", 64'(wb_waddr), 64'd2);
        chk("sim_w2_data", 64'(wb_wdata), 64'hA111_1111);
        chk("sim_ready2",  64'(src_ready), 64'b111);
        step();
        chk("sim_w3_addr", 64'(wb_waddr), 64'd3);
        chk("sim_w3_data", 64'(wb_wdata), 64'hA222_2222);
        chk("sim_w3_busy", 64'(wb_busy),  64'd0);
        step();
        chk("sim_idle_addr", 64'(wb_waddr), 64'd0);
        chk("sim_idle_data", 64'(wb_wdata), 64'hA222_2222);

        // Single write from source 0
        set_src(0, 5'd5, 32'hDEAD_BEEF);
        src_valid = 3'b001;
        step();
        src_valid = 3'b000;
        chk("one_lat_addr", 64'(wb_waddr), 64'd0);
        chk("one_lat_busy", 64'(wb_busy),  64'd1);
        step();
        chk("one_addr", 64'(wb_waddr), 64'd5);
        chk("one_data", 64'(wb_wdata), 64'hDEAD_BEEF);
        chk("one_busy", 64'(wb_busy),  64'd0);
        step();
        chk("one_after_addr", 64'(wb_waddr), 64'd0);

        // Fairness: pointer sits at 1 after the single write, so order is 1,2,0,...
        set_src(0, 5'd11, 32'h0000_0B00);
        set_src(1, 5'd12, 32'h0000_0C00);
        set_src(2, 5'd13, 32'h0000_0D00);
        src_valid = 3'b111;
        step();
        chk("fair_first_gap", 64'(wb_waddr), 64'd0);
        for (int n = 0; n < 30; n++) begin
            step();
            chk("fair_seq", 64'(wb_waddr), 64'(11 + ((1 + n) % 3)));
            if (wb_waddr >= 5'd11 && wb_waddr <= 5'd13) begin
                cnt[wb_waddr - 5'd11]++;
            end
        end
        chk("fair_cnt0", 64'(cnt[0]), 64'd10);
        chk("fair_cnt1", 64'(cnt[1]), 64'd10);
        chk("fair_cnt2", 64'(cnt[2]), 64'd10);

        // Flush with all buffers full and sources still valid
        flush = 1'b1;
        #1;
        chk("flush_ready", 64'(src_ready), 64'b000);
        step();
        flush     = 1'b0;
        src_valid = 3'b000;
        chk("flush_addr", 64'(wb_waddr), 64'd0);
        chk("flush_busy", 64'(wb_busy),  64'd0);
        step();
        chk("flush_idle", 64'(wb_waddr), 64'd0);

        // Pointer held across flush: next winner is source 1
        set_src(0, 5'd21, 32'h2100_0000);
        set_src(1, 5'd22, 32'h2200_0000);
        set_src(2, 5'd23, 32'h2300_0000);
        src_valid = 3'b111;
        step();
        src_valid = 3'b000;
        step();
        chk("ptr_hold_addr", 64'(wb_waddr), 64'd22);
        chk("ptr_hold_data", 64'(wb_wdata), 64'h2200_0000);
        chk("ptr_hold_busy", 64'(wb_busy),  64'd1);

        // Asynchronous reset with buffers 0 and 2 still occupied
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_addr",  64'(wb_waddr),  64'd0);
        chk("arst_data",  64'(wb_wdata),  64'd0);
        chk("arst_busy",  64'(wb_busy),   64'd0);
        chk("arst_ready", 64'(src_ready), 64'b000);
        @(negedge clk);
        resetn = 1'b1;
        set_src(0, 5'd7, 32'h7777_7777);
        set_src(2, 5'd9, 32'h9999_9999);
        src_valid = 3'b101;
        step();
        src_valid = 3'b000;
        step();
        chk("arst_first_addr", 64'(wb_waddr), 64'd7);
        chk("arst_first_data", 64'(wb_wdata), 64'h7777_7777);
        step();
        chk("arst_second_addr", 64'(wb_waddr), 64'd9);
        step();
        chk("arst_drain_addr", 64'(wb_waddr), 64'd0);

        // Zero destination: accepted, never buffered or written
        set_src(1, 5'd0, 32'h0000_1234);
        src_valid = 3'b010;
        #1;
        chk("zero_ready", 64'(src_ready), 64'b111);
        step();
        src_valid = 3'b000;
        chk("zero_busy", 64'(wb_busy),  64'd0);
        chk("zero_addr", 64'(wb_waddr), 64'd0);
        step();
        chk("zero_addr2", 64'(wb_waddr), 64'd0);
        chk("zero_data",  64'(wb_wdata), 64'h9999_9999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
